// File: rtl/fft_page_writeback_if.sv
// Beat input and memory write port of fft_page_writeback.
// slave is the block's view; master is the surrounding logic's view.
interface fft_page_writeback_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              i_valid;
  logic              o_ready;
  logic [127:0]      i_write_val1;
  logic [127:0]      i_write_val2;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [127:0]      o_mem_wdata;
  logic              i_mem_stall;
  logic              o_frame_done;
  logic              o_busy;

  modport slave (
    input  i_valid, i_write_val1, i_write_val2, i_mem_stall,
    output o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_frame_done, o_busy
  );

  modport master (
    output i_valid, i_write_val1, i_write_val2, i_mem_stall,
    input  o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_frame_done, o_busy
  );
endinterface

// File: rtl/fft_page_writeback.sv
// Buffers FFT page result beats and serialises each as a top then bottom 128-bit memory write.
// Define PAGE_WB_BITREV_EN to write beats in bit-reversed (natural DIF output) order.
module fft_page_writeback #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 6
) (
  input logic                clock,
  input logic                reset_n,
  fft_page_writeback_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = ADDR_W - 1;

  typedef enum logic [1:0] {StIdle, StWrTop, StWrBot} state_e;

  logic [127:0]     top_mem [DEPTH];
  logic [127:0]     bot_mem [DEPTH];
  logic [IDX_W-1:0] idx_mem [DEPTH];
  logic [DEPTH-1:0] last_mem;

  state_e            state_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  k_q, in_idx;
  logic              ready_q, we_q, frame_done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [127:0]      wdata_q;

  logic             accept, pop, nxt_from_mem, nxt_avail;
  logic [PTR_W-1:0] nxt_ptr;
  logic [IDX_W-1:0] nxt_idx;
  logic [127:0]     nxt_top;

  assign accept  = bus.i_valid && ready_q;
  assign pop     = (state_q == StWrBot) && !bus.i_mem_stall;
  assign count_d = count_q + CNT_W'(accept) - CNT_W'(pop);

`ifdef PAGE_WB_BITREV_EN
  always_comb begin
    in_idx = '0;
    for (int i = 0; i < int'(IDX_W); i++) begin
      in_idx[i] = k_q[IDX_W-1-i];
    end
  end
`else
  assign in_idx = k_q;
`endif

  // Entry that becomes the head once the current write finishes; an empty FIFO
  // bypasses the incoming beat so its top write starts on the very next cycle.
  always_comb begin
    if (state_q == StWrBot) begin
      nxt_from_mem = count_q > CNT_W'(1);
      nxt_ptr      = rd_ptr_q + PTR_W'(1);
    end else begin
      nxt_from_mem = count_q != '0;
      nxt_ptr      = rd_ptr_q;
    end
    nxt_avail = nxt_from_mem || accept;
    nxt_idx   = nxt_from_mem ? idx_mem[nxt_ptr] : in_idx;
    nxt_top   = nxt_from_mem ? top_mem[nxt_ptr] : bus.i_write_val1;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      top_mem[wr_ptr_q]  <= bus.i_write_val1;
      bot_mem[wr_ptr_q]  <= bus.i_write_val2;
      idx_mem[wr_ptr_q]  <= in_idx;
      last_mem[wr_ptr_q] <= &k_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      k_q          <= '0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ready_q      <= count_d != CNT_W'(DEPTH);
      count_q      <= count_d;
      frame_done_q <= 1'b0;
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        k_q      <= k_q + IDX_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (nxt_avail) begin
            state_q <= StWrTop;
            we_q    <= 1'b1;
            addr_q  <= {1'b0, nxt_idx};
            wdata_q <= nxt_top;
          end
        end
        StWrTop: begin
          if (!bus.i_mem_stall) begin
            state_q <= StWrBot;
            addr_q  <= {1'b1, idx_mem[rd_ptr_q]};
            wdata_q <= bot_mem[rd_ptr_q];
          end
        end
        StWrBot: begin
          if (!bus.i_mem_stall) begin
            rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
            frame_done_q <= last_mem[rd_ptr_q];
            if (nxt_avail) begin
              state_q <= StWrTop;
              addr_q  <= {1'b0, nxt_idx};
              wdata_q <= nxt_top;
            end else begin
              state_q <= StIdle;
              we_q    <= 1'b0;
              addr_q  <= '0;
              wdata_q <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_mem_we     = we_q;
  assign bus.o_mem_addr   = addr_q;
  assign bus.o_mem_wdata  = wdata_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_busy       = count_q != '0;
endmodule

// File: tb/tb_fft_page_writeback.sv
// Bench for fft_page_writeback: directed scenarios plus random valid/stall traffic,
// checked every cycle against a queue of expected memory writes.
module tb_fft_page_writeback;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned HALF   = 1 << (ADDR_W - 1);

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  fft_page_writeback_if #(.ADDR_W(ADDR_W)) bus ();

  fft_page_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [127:0]      data;
    bit                last;
  } wr_t;

  wr_t               wq[$];
  int                checks, errors;
  int                m_count, kk;
  bit                m_rdy_ok, exp_fd;
  bit                prev_we, prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [127:0]      prev_data;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Slot in memory for beat number k within a frame.
  function automatic int ref_idx(input int k);
`ifdef PAGE_WB_BITREV_EN
    int r = 0;
    int v = k;
    for (int i = 0; i < int'(ADDR_W) - 1; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
`else
    return k;
`endif
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, bus.o_ready, 0);
    check({tag, "_we"}, bus.o_mem_we, 0);
    check({tag, "_addr"}, bus.o_mem_addr, 0);
    check({tag, "_wdata"}, bus.o_mem_wdata, 0);
    check({tag, "_fdone"}, bus.o_frame_done, 0);
    check({tag, "_busy"}, bus.o_busy, 0);
  endtask

  task automatic model_clear();
    wq.delete();
    m_count  = 0;
    kk       = 0;
    m_rdy_ok = 0;
    exp_fd   = 0;
    prev_we  = 0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step(output bit acc);
    bit  cmp;
    wr_t h;
    @(negedge clock);
    check("ready", bus.o_ready, m_rdy_ok && (m_count != DEPTH));
    check("busy", bus.o_busy, m_count != 0);
    check("frame_done", bus.o_frame_done, exp_fd);
    check("we", bus.o_mem_we, wq.size() != 0);
    if (wq.size() != 0 && bus.o_mem_we) begin
      check("addr", bus.o_mem_addr, wq[0].addr);
      check("wdata", bus.o_mem_wdata, wq[0].data);
    end
    if (prev_we && prev_stall) begin
      check("hold_addr", bus.o_mem_addr, prev_addr);
      check("hold_wdata", bus.o_mem_wdata, prev_data);
    end
    prev_we    = bus.o_mem_we;
    prev_stall = bus.i_mem_stall;
    prev_addr  = bus.o_mem_addr;
    prev_data  = bus.o_mem_wdata;
    acc = bus.i_valid && m_rdy_ok && (m_count != DEPTH);
    cmp = (wq.size() != 0) && !bus.i_mem_stall;
    @(posedge clock);
    exp_fd = 0;
    if (cmp) begin
      h = wq.pop_front();
      if (h.addr >= HALF) begin
        m_count--;
        exp_fd = h.last;
      end
    end
    if (acc) begin
      wq.push_back('{addr: ADDR_W'(ref_idx(kk)), data: bus.i_write_val1, last: 1'b0});
      wq.push_back('{addr: ADDR_W'(ref_idx(kk) + HALF), data: bus.i_write_val2,
                     last: (kk == HALF - 1)});
      m_count++;
      kk = (kk + 1) % HALF;
    end
    m_rdy_ok = 1;
    #1;
  endtask

  task automatic idle_steps(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  initial begin
    bit acc;
    bit saw_full;
    int beats, guard;
    checks = 0;
    errors = 0;
    model_clear();
    bus.i_valid      = 0;
    bus.i_mem_stall  = 0;
    bus.i_write_val1 = '0;
    bus.i_write_val2 = '0;
    reset_n = 1;
    #1 reset_n = 0;
    #2 reset_checks("rst_async");
    repeat (2) @(posedge clock);
    #1 reset_checks("rst_clocked");
    reset_n = 1;

    // Single beat, no stall.
    idle_steps(2);
    bus.i_valid      = 1;
    bus.i_write_val1 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    bus.i_write_val2 = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
    step(acc);
    check("single_accept", acc, 1);
    bus.i_valid = 0;
    idle_steps(4);

    // Eight beats with i_valid held high; the FIFO must fill and throttle.
    beats    = 0;
    guard    = 0;
    saw_full = 0;
    bus.i_valid = 1;
    while (beats < 8 && guard < 100) begin
      bus.i_write_val1 = rnd128();
      bus.i_write_val2 = rnd128();
      step(acc);
      if (acc) beats++;
      if (m_count == DEPTH) saw_full = 1;
      guard++;
    end
    check("burst_beats", beats, 8);
    check("burst_full", saw_full, 1);
    bus.i_valid = 0;
    idle_steps(20);

    // Three-cycle stall during a top write.
    bus.i_valid      = 1;
    bus.i_write_val1 = rnd128();
    bus.i_write_val2 = rnd128();
    step(acc);
    bus.i_valid     = 0;
    bus.i_mem_stall = 1;
    idle_steps(3);
    bus.i_mem_stall = 0;
    idle_steps(5);

    // Asynchronous reset with two beats buffered and a write pending.
    bus.i_valid     = 1;
    bus.i_mem_stall = 1;
    for (int i = 0; i < 2; i++) begin
      bus.i_write_val1 = rnd128();
      bus.i_write_val2 = rnd128();
      step(acc);
    end
    check("pre_reset_busy", bus.o_busy, 1);
    reset_n = 0;
    #2 reset_checks("rst_mid");
    model_clear();
    bus.i_valid     = 0;
    bus.i_mem_stall = 0;
    @(posedge clock);
    #1 reset_checks("rst_mid_clk");
    reset_n = 1;
    bus.i_valid      = 1;
    bus.i_write_val1 = rnd128();
    bus.i_write_val2 = rnd128();
    step(acc);
    check("post_reset_no_accept", acc, 0);
    step(acc);
    check("post_reset_accept", acc, 1);
    bus.i_valid = 0;
    idle_steps(4);

    // Random traffic spanning many frames.
    for (int i = 0; i < 1500; i++) begin
      bus.i_valid      = ($urandom % 4) != 0;
      bus.i_mem_stall  = ($urandom % 4) == 0;
      bus.i_write_val1 = rnd128();
      bus.i_write_val2 = rnd128();
      step(acc);
    end
    bus.i_valid     = 0;
    bus.i_mem_stall = 0;
    idle_steps(20);
    check("drained", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
